// File: rtl/axi4_lite_dmem_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite data-memory controller.
//   state_e         controller FSM states
//   RESP_OKAY/...   AXI response codes
//   MEM_ADDR_W      width of the word-index ports toward data_mem
//   word_idx_w()    word-index bits needed for a given MEM_WORDS
package axi4_lite_dmem_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRwait,
        StRresp
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned MEM_ADDR_W = 12;

    function automatic int unsigned word_idx_w(input int unsigned mem_words);
        return (mem_words > 1) ? $clog2(mem_words) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_dmem_ctrl.sv
// AXI4-Lite slave in front of a synchronous-read data memory.
// One transaction in flight; AW and W are captured independently into holding registers and the
// write fires once both are present. Writes win over a simultaneous read.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*     AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*        AXI4-Lite read address and data channels
//   mem_write, byte_en, write_addr, write_data   write port toward data_mem
//   read_addr, read_data                        read port (data valid one clock after address)
module axi4_lite_dmem_ctrl
    import axi4_lite_dmem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  mem_write,
    output logic [3:0]            byte_en,
    output logic [31:0]           write_data,
    output logic [MEM_ADDR_W-1:0] write_addr,
    output logic [MEM_ADDR_W-1:0] read_addr,
    input  logic [31:0]           read_data
);

    localparam int unsigned IdxW      = word_idx_w(MEM_WORDS);
    localparam int unsigned ByteAddrW = IdxW + 2;

    // Byte address -> zero-extended word index; bits [1:0] are dropped.
    function automatic logic [MEM_ADDR_W-1:0] to_word(input logic [31:0] a);
        logic [MEM_ADDR_W-1:0] r;
        r            = '0;
        r[IdxW-1:0]  = a[ByteAddrW-1:2];
        return r;
    endfunction

    // Any bit above the memory window makes the access a slave error.
    function automatic logic addr_err(input logic [31:0] a);
        return |(a >> ByteAddrW);
    endfunction

    state_e                state_q, state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  aw_err_q, aw_err_d;
    logic [MEM_ADDR_W-1:0] aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  ar_err_q, ar_err_d;
    logic [MEM_ADDR_W-1:0] ar_idx_q, ar_idx_d;

    logic aw_hs, w_hs, ar_hs, wr_go;

    assign s_axi_awready = (state_q == StIdle) && !aw_held_q;
    assign s_axi_wready  = (state_q == StIdle) && !w_held_q;
    // A read is only taken when no write half is held or being offered.
    assign s_axi_arready = (state_q == StIdle) && !aw_held_q && !w_held_q &&
                           !s_axi_awvalid && !s_axi_wvalid;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign wr_go = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    always_comb begin
        state_d      = state_q;
        aw_held_d    = aw_held_q;
        aw_err_d     = aw_err_q;
        aw_idx_d     = aw_idx_q;
        w_held_d     = w_held_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        ar_err_d     = ar_err_q;
        ar_idx_d     = ar_idx_q;
        mem_write    = 1'b0;
        byte_en      = 4'b0000;
        s_axi_bvalid = 1'b0;
        s_axi_rvalid = 1'b0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = to_word(s_axi_awaddr);
            aw_err_d  = addr_err(s_axi_awaddr);
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (ar_hs) begin
            ar_idx_d = to_word(s_axi_araddr);
            ar_err_d = addr_err(s_axi_araddr);
        end

        unique case (state_q)
            StIdle: begin
                if (wr_go) begin
                    state_d = StWrite;
                end else if (ar_hs) begin
                    state_d = StRwait;
                end
            end
            StWrite: begin
                mem_write = !aw_err_q;
                byte_en   = aw_err_q ? 4'b0000 : wstrb_q;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                state_d   = StWresp;
            end
            StWresp: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_d = StIdle;
                end
            end
            StRwait: begin
                state_d = StRresp;
            end
            StRresp: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            aw_held_q <= 1'b0;
            aw_err_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ar_err_q  <= 1'b0;
            ar_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            aw_err_q  <= aw_err_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            ar_err_q  <= ar_err_d;
            ar_idx_q  <= ar_idx_d;
        end
    end

    // Response codes come from the error flags captured with the address; the address
    // registers cannot change until the FSM is back in idle, so responses stay stable.
    assign s_axi_bresp = (state_q == StWresp && aw_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rresp = (state_q == StRresp && ar_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rdata = (state_q == StRresp && !ar_err_q) ? read_data : 32'h0;

    assign write_addr = aw_idx_q;
    assign write_data = wdata_q;
    // Held through RRESP so the memory keeps returning the same word under backpressure.
    assign read_addr  = ar_idx_q;

endmodule
